scoreboard_ctrl: RTL and testbench
==================================

# scoreboard_ctrl

Two-team score controller: four asynchronous push-button requests (team A up/down, team B up/down) share a single saturating update unit. Each request is synchronized, edge-detected and queued as a pending bit. A round-robin arbiter grants one request per clock to the update unit. The unit modifies the selected team's score, clamped to 0..MAX. The block feeds the 7-segment display path and replaces per-button clocking of score counters with one clock domain.

## Interface

- BW, 7, score width in bits
- MAX, 99, upper score limit (inclusive), must be < 2^BW

- clk_i  input  1  system clock, all state on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- a_up_i  input  1  raw button, team A increment (asynchronous, level)
- a_dn_i  input  1  raw button, team A decrement
- b_up_i  input  1  raw button, team B increment
- b_dn_i  input  1  raw button, team B decrement
- clear_i  input  1  synchronous clear of both scores (already in clk_i domain)
- score_a_o  output  BW  team A score, registered
- score_b_o  output  BW  team B score, registered
- upd_valid_o  output  1  one-cycle pulse, a request was serviced
- upd_src_o  output  2  serviced source: 0=A up, 1=A dn, 2=B up, 3=B dn
- sat_o  output  1  with upd_valid_o: request hit a limit, score unchanged

## Operation

- **Reset** (rst_n_i low, asynchronous):
  - All registers are 0: sync flops, edge-history flops, pending[3:0], rr pointer, scores, upd_valid_o, upd_src_o, sat_o.
- **Per-source front end**:
  - 2-flop synchronizer s1→s2, plus history flop p.
  - edge = s2 & ~p.
  - edge sets pending[n]. Holding a button produces exactly one request.
  - An edge while pending[n] is already set is dropped; there is no counting of multiple presses.
- **Arbiter**:
  - Round-robin over pending[3:0].
  - Search starts at pointer ptr (2 bits) and wraps 3→0.
  - The first set bit is granted.
  - On grant: ptr ← granted+1 (mod 4), pending[granted] cleared.
  - No grant: ptr holds.
  - If pending[n] is cleared by a grant in the same cycle that a new edge for n arrives, the set wins (pending stays 1).
- **Update unit**, acting on the granted source:
  - up: if score < MAX then score+1, else unchanged and sat=1.
  - dn: if score > 0 then score−1, else unchanged and sat=1.
  - Only the selected team's score changes.
  - The other score is untouched.
- **Registered outputs** in the grant cycle: upd_valid_o=1, upd_src_o=granted, sat_o as computed.
- **No grant**: upd_valid_o=0 and sat_o=0; upd_src_o holds its last value.
- **clear_i** has highest priority, at the same edge:
  - Scores ← 0, pending ← 0, ptr ← 0, upd_valid_o ← 0, sat_o ← 0.
  - Edges detected in a clear cycle are discarded.
  - Sync/history flops keep running.
- **Score invariant**: score values never leave 0..MAX, including immediately after reset.

## Timing

- **Latency**:
  - Raw input first sampled high at edge k: s2=1 after k+1, pending set at k+2.
  - If granted immediately, the score and upd_valid_o update at edge k+3.
  - Worst-case added wait is 3 cycles, when all four sources are pending; max total k+6.
- **Throughput**: one serviced request per cycle; upd_valid_o may be high on consecutive cycles.
- **Release**: a button release generates no request; re-press requires s2 to be seen low for ≥1 cycle.
- **Reset mid-operation**: pending requests are lost and scores return to 0 asynchronously. The first request after deassertion follows the normal k+3 latency.

## Test plan

- **Reset then single press**:
  - Stimulus: rst_n_i low→high, then a_up_i high for 10 cycles.
  - Required: score_a_o 0→1 exactly 3 cycles after first sample; one upd_valid_o pulse with upd_src_o=0 and sat_o=0; score_b_o stays 0.
- **Saturation**:
  - Stimulus: 99 separate a_up_i presses, then one more.
  - Required: score_a_o=99; the last press gives upd_valid_o=1, sat_o=1, score_a_o stays 99.
  - Also: b_dn_i at score_b_o=0 gives sat_o=1, score stays 0.
- **Simultaneous presses**:
  - Stimulus: all four inputs rise in the same cycle from scores A=5, B=5 with ptr=0.
  - Required: grants in order 0,1,2,3 on four consecutive cycles; final A=5, B=5.
- **Round-robin fairness**:
  - Stimulus: ptr=2 after serving source 1, then sources 0 and 3 pending together.
  - Required: source 3 is granted first, then source 0.
- **Clear precedence**:
  - Stimulus: scores A=42, B=17 with pending[2] set; assert clear_i for 1 cycle.
  - Required: both scores read 0 next cycle, no upd_valid_o, and pending request 2 is never serviced.
- **Async reset mid-operation**:
  - Stimulus: drop rst_n_i between clock edges while requests are pending.
  - Required: outputs go to 0 immediately without a clock edge; no stale upd_valid_o after release.

Source files
------------

// File: rtl/scoreboard_ctrl.sv
// Two-team score controller: four async buttons are synchronized,
// edge-detected, queued and round-robin arbitrated into one saturating
// score update unit.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   a_up_i, a_dn_i, b_up_i, b_dn_i raw asynchronous buttons
//   clear_i                        sync clear of scores and queue
//   score_a_o, score_b_o           registered scores, 0..MAX
//   upd_valid_o, upd_src_o, sat_o  per-grant update report
module scoreboard_ctrl #(
    parameter int BW  = 7,
    parameter int MAX = 99
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          a_up_i,
    input  logic          a_dn_i,
    input  logic          b_up_i,
    input  logic          b_dn_i,
    input  logic          clear_i,
    output logic [BW-1:0] score_a_o,
    output logic [BW-1:0] score_b_o,
    output logic          upd_valid_o,
    output logic [1:0]    upd_src_o,
    output logic          sat_o
);

    localparam logic [BW-1:0] MAX_V = BW'(MAX);

    logic [3:0]    raw;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    hist;
    logic [3:0]    edge_w;
    logic [3:0]    pending;
    logic [3:0]    pending_nxt;
    logic [3:0]    gnt_mask;
    logic [1:0]    ptr;
    logic [1:0]    cand;
    logic [1:0]    gnt_idx;
    logic          gnt_v;
    logic [BW-1:0] cur;
    logic [BW-1:0] nxt_score;
    logic          sat_c;

    // Bit order matches upd_src_o encoding.
    assign raw = {b_dn_i, b_up_i, a_dn_i, a_up_i};

    // Front end keeps running through clear_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1   <= '0;
            s2   <= '0;
            hist <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign edge_w = s2 & ~hist;

    // Scan offsets high to low so the nearest set bit from ptr wins.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (pending[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        cur       = gnt_idx[1] ? score_b_o : score_a_o;
        nxt_score = cur;
        sat_c     = 1'b0;
        if (gnt_idx[0]) begin
            if (cur == '0) sat_c = 1'b1;
            else           nxt_score = cur - 1'b1;
        end else begin
            if (cur >= MAX_V) sat_c = 1'b1;
            else              nxt_score = cur + 1'b1;
        end
    end

    // A new edge re-sets a bit cleared by its own grant.
    assign gnt_mask    = gnt_v ? (4'b0001 << gnt_idx) : 4'b0000;
    assign pending_nxt = (pending & ~gnt_mask) | edge_w;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending     <= '0;
            ptr         <= '0;
            score_a_o   <= '0;
            score_b_o   <= '0;
            upd_valid_o <= 1'b0;
            upd_src_o   <= '0;
            sat_o       <= 1'b0;
        end else if (clear_i) begin
            pending     <= '0;
            ptr         <= '0;
            score_a_o   <= '0;
            score_b_o   <= '0;
            upd_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            upd_valid_o <= gnt_v;
            sat_o       <= gnt_v & sat_c;
            if (gnt_v) begin
                ptr       <= gnt_idx + 2'd1;
                upd_src_o <= gnt_idx;
                if (gnt_idx[1]) score_b_o <= nxt_score;
                else            score_a_o <= nxt_score;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Self-checking bench for scoreboard_ctrl: table vectors, a queue of
// expected updates checked by a monitor, and hand-written corner cases.
module tb_scoreboard_ctrl;

    localparam int BW  = 7;
    localparam int MAX = 99;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [3:0]    btn;
    logic          clear_i;
    logic [BW-1:0] score_a_o;
    logic [BW-1:0] score_b_o;
    logic          upd_valid_o;
    logic [1:0]    upd_src_o;
    logic          sat_o;

    scoreboard_ctrl #(.BW(BW), .MAX(MAX)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .a_up_i      (btn[0]),
        .a_dn_i      (btn[1]),
        .b_up_i      (btn[2]),
        .b_dn_i      (btn[3]),
        .clear_i     (clear_i),
        .score_a_o   (score_a_o),
        .score_b_o   (score_b_o),
        .upd_valid_o (upd_valid_o),
        .upd_src_o   (upd_src_o),
        .sat_o       (sat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int src;
        int sat;
        int a;
        int b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   a_m   = 0;
    int   b_m   = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Reference arithmetic for one serviced request.
    task automatic push_exp(input int src);
        exp_t e;
        int   s;
        s = 0;
        case (src)
            0: if (a_m < MAX) a_m++; else s = 1;
            1: if (a_m > 0)   a_m--; else s = 1;
            2: if (b_m < MAX) b_m++; else s = 1;
            default: if (b_m > 0) b_m--; else s = 1;
        endcase
        e.src = src;
        e.sat = s;
        e.a   = a_m;
        e.b   = b_m;
        q.push_back(e);
    endtask

    task automatic press_mask(input logic [3:0] m);
        @(negedge clk_i);
        btn = m;
        repeat (3) @(negedge clk_i);
        btn = 4'b0000;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic press(input int src);
        push_exp(src);
        press_mask(4'b0001 << src);
    endtask

    task automatic do_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        a_m = 0;
        b_m = 0;
    endtask

    // Single a_up press, checking the exact k+3 update edge.
    task automatic latency_press(input string tag);
        push_exp(0);
        @(negedge clk_i);
        btn = 4'b0001;
        repeat (3) @(negedge clk_i);
        chk({tag, "_k2_a"}, int'(score_a_o), a_m - 1);
        chk({tag, "_k2_vld"}, int'(upd_valid_o), 0);
        @(negedge clk_i);
        chk({tag, "_k3_a"}, int'(score_a_o), a_m);
        chk({tag, "_k3_vld"}, int'(upd_valid_o), 1);
        chk({tag, "_k3_src"}, int'(upd_src_o), 0);
        chk({tag, "_k3_b"}, int'(score_b_o), b_m);
        repeat (6) @(negedge clk_i);
        btn = 4'b0000;
        repeat (6) @(negedge clk_i);
    endtask

    // Every update pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (upd_valid_o) begin
                if (q.size() == 0) begin
                    chk("mon_unexpected_vld", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("mon_src", int'(upd_src_o), e.src);
                    chk("mon_sat", int'(sat_o), e.sat);
                    chk("mon_a", int'(score_a_o), e.a);
                    chk("mon_b", int'(score_b_o), e.b);
                end
            end else begin
                if (sat_o) chk("mon_sat_idle", 1, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    exp_t vec[7];

    initial begin
        vec[0] = '{src: 1, sat: 0, a: 0, b: 0};
        vec[1] = '{src: 1, sat: 1, a: 0, b: 0};
        vec[2] = '{src: 3, sat: 1, a: 0, b: 0};
        vec[3] = '{src: 2, sat: 0, a: 0, b: 1};
        vec[4] = '{src: 2, sat: 0, a: 0, b: 2};
        vec[5] = '{src: 3, sat: 0, a: 0, b: 1};
        vec[6] = '{src: 0, sat: 0, a: 1, b: 1};

        rst_n_i = 1'b0;
        btn     = 4'b0000;
        clear_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_a", int'(score_a_o), 0);
        chk("rst_b", int'(score_b_o), 0);
        chk("rst_vld", int'(upd_valid_o), 0);
        chk("rst_src", int'(upd_src_o), 0);
        chk("rst_sat", int'(sat_o), 0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        latency_press("first");

        for (int i = 0; i < 7; i++) begin
            q.push_back(vec[i]);
            a_m = vec[i].a;
            b_m = vec[i].b;
            press_mask(4'b0001 << vec[i].src);
            chk($sformatf("vec%0d_a", i), int'(score_a_o), vec[i].a);
            chk($sformatf("vec%0d_b", i), int'(score_b_o), vec[i].b);
        end

        while (a_m < MAX) press(0);
        chk("sat_a_max", int'(score_a_o), MAX);
        press(0);
        chk("sat_a_hold", int'(score_a_o), MAX);

        // Reach A=5, B=5 with ptr back at 0 after a source-3 grant.
        do_clear();
        repeat (5) press(0);
        repeat (6) press(2);
        press(3);
        chk("sim_pre_a", int'(score_a_o), 5);
        chk("sim_pre_b", int'(score_b_o), 5);
        for (int j = 0; j < 4; j++) push_exp(j);
        @(negedge clk_i);
        btn = 4'b1111;
        repeat (3) @(negedge clk_i);
        btn = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_i);
            chk($sformatf("sim_vld%0d", j), int'(upd_valid_o), 1);
            chk($sformatf("sim_src%0d", j), int'(upd_src_o), j);
        end
        repeat (6) @(negedge clk_i);
        chk("sim_fin_a", int'(score_a_o), 5);
        chk("sim_fin_b", int'(score_b_o), 5);

        // Serve source 1 so ptr=2, then 0 and 3 together: 3 goes first.
        press(1);
        push_exp(3);
        push_exp(0);
        press_mask(4'b1001);
        chk("rr_a", int'(score_a_o), 5);
        chk("rr_b", int'(score_b_o), 4);

        // Clear in the cycle pending[2] would be granted.
        do_clear();
        repeat (42) press(0);
        repeat (17) press(2);
        chk("clr_pre_a", int'(score_a_o), 42);
        chk("clr_pre_b", int'(score_b_o), 17);
        @(negedge clk_i);
        btn = 4'b0100;
        repeat (3) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        a_m = 0;
        b_m = 0;
        chk("clr_a", int'(score_a_o), 0);
        chk("clr_b", int'(score_b_o), 0);
        chk("clr_vld", int'(upd_valid_o), 0);
        repeat (8) @(negedge clk_i);
        btn = 4'b0000;
        repeat (6) @(negedge clk_i);
        chk("clr_post_b", int'(score_b_o), 0);

        // Async reset right after the first of four grants.
        press(0);
        press(0);
        press(3);
        push_exp(0);
        @(negedge clk_i);
        btn = 4'b1111;
        repeat (4) @(negedge clk_i);
        chk("ar_pre_vld", int'(upd_valid_o), 1);
        chk("ar_pre_a", int'(score_a_o), 3);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("ar_a", int'(score_a_o), 0);
        chk("ar_vld", int'(upd_valid_o), 0);
        chk("ar_src", int'(upd_src_o), 0);
        a_m = 0;
        b_m = 0;
        btn = 4'b0000;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("ar_post_a", int'(score_a_o), 0);
        chk("ar_post_b", int'(score_b_o), 0);
        latency_press("after_rst");

        repeat (5) @(negedge clk_i);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
